// File: rtl/dbuf_pkg.sv
// Shared types and sizing helpers for the ping-pong row buffer.
package dbuf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_MATRIX_SIZE = 3;

    typedef logic [DEF_DATA_WIDTH*DEF_MATRIX_SIZE-1:0] row_t;

    // Row address width; never below one bit so tiny depths still elaborate.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Row count width, wide enough to hold the value DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dbuf_bank.sv
// One bank of row storage: synchronous write port, combinational read port.
module dbuf_bank
    import dbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROW_W = 24,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic [PW-1:0]    rd_addr,
    output logic [ROW_W-1:0] rd_data
);

    // Contents are deliberately unreset; validity is tracked by the bank state.
    logic [ROW_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/double_buffer_stream.sv
// Ping-pong row buffer with valid/ready on both sides and automatic bank swap.
// Define DOUBLE_BUFFER_REPLAY_EN to let the consumer re-stream a batch via rd_replay.
module double_buffer_stream
    import dbuf_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic                              wr_last,
    input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] wr_data_flat,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic                              rd_last,
    input  logic                              rd_replay,
    output logic [DATA_WIDTH*MATRIX_SIZE-1:0] rd_data_flat,
    output logic                              drain_sel,
    output logic [$clog2(DEPTH+1)-1:0]        fill_count
);

    localparam int ROW_W = DATA_WIDTH * MATRIX_SIZE;
    localparam int PW    = ptr_width(DEPTH);
    localparam int CW    = count_width(DEPTH);

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic [CW-1:0]    len_q [2];
    logic [CW-1:0]    len_d [2];
    logic             drain_sel_q, drain_sel_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fill_count_q, fill_count_d;

    logic             fill_sel;
    logic             wr_fire;
    logic             rd_fire;
    logic             close_batch;
    logic             replay_take;
    logic             rd_valid_int;
    logic             rd_last_int;
    logic [PW-1:0]    wr_ptr;
    logic [ROW_W-1:0] bank_rd [2];

`ifdef DOUBLE_BUFFER_REPLAY_EN
    assign replay_take = rd_replay;
`else
    assign replay_take = rd_replay & 1'b0;
`endif

    assign fill_sel     = ~drain_sel_q;
    assign wr_ptr       = fill_count_q[PW-1:0];
    assign wr_ready     = (state_q[fill_sel] != BANK_FULL);
    assign rd_valid_int = (state_q[drain_sel_q] == BANK_DRAINING);
    assign rd_last_int  = rd_valid_int && (CW'(rd_ptr_q) == (len_q[drain_sel_q] - CW'(1)));
    assign wr_fire      = wr_valid && wr_ready;
    assign rd_fire      = rd_valid_int && rd_ready;
    assign close_batch  = (fill_count_q == CW'(DEPTH - 1)) || wr_last;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        drain_sel_d  = drain_sel_q;
        rd_ptr_d     = rd_ptr_q;
        fill_count_d = fill_count_q;

        if (wr_fire) begin
            fill_count_d = fill_count_q + CW'(1);
            if (close_batch) begin
                state_d[fill_sel] = BANK_FULL;
                len_d[fill_sel]   = fill_count_q + CW'(1);
            end else begin
                state_d[fill_sel] = BANK_FILLING;
            end
        end

        if (rd_fire) begin
            if (rd_last_int) begin
                rd_ptr_d = '0;
                if (!replay_take) begin
                    state_d[drain_sel_q] = BANK_EMPTY;
                end
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        // Swap looks at next-state so a same-edge close/release leaves no bubble.
        if (state_d[fill_sel] == BANK_FULL && state_d[drain_sel_q] == BANK_EMPTY) begin
            state_d[fill_sel] = BANK_DRAINING;
            drain_sel_d       = fill_sel;
            rd_ptr_d          = '0;
            fill_count_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= BANK_EMPTY;
                len_q[b]   <= '0;
            end
            drain_sel_q  <= 1'b0;
            rd_ptr_q     <= '0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            drain_sel_q  <= drain_sel_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_count_q <= fill_count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            dbuf_bank #(
                .DEPTH (DEPTH),
                .ROW_W (ROW_W),
                .PW    (PW)
            ) u_bank (
                .clk     (clk),
                .wr_en   (wr_fire && (fill_sel == 1'(gi))),
                .wr_addr (wr_ptr),
                .wr_data (wr_data_flat),
                .rd_addr (rd_ptr_q),
                .rd_data (bank_rd[gi])
            );
        end
    endgenerate

    assign rd_valid     = rd_valid_int;
    assign rd_last      = rd_last_int;
    assign rd_data_flat = rd_valid_int ? bank_rd[drain_sel_q] : '0;
    assign drain_sel    = drain_sel_q;
    assign fill_count   = fill_count_q;

endmodule

// File: tb/tb_double_buffer_stream.sv
// Directed bench for double_buffer_stream (DATA_WIDTH=8, MATRIX_SIZE=3, DEPTH=4).
module tb_double_buffer_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready, wr_last;
    logic [23:0] wr_data_flat;
    logic        rd_valid, rd_ready, rd_last, rd_replay;
    logic [23:0] rd_data_flat;
    logic        drain_sel;
    logic [2:0]  fill_count;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    double_buffer_stream #(
        .DATA_WIDTH  (8),
        .MATRIX_SIZE (3),
        .DEPTH       (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_last      (wr_last),
        .wr_data_flat (wr_data_flat),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .rd_replay    (rd_replay),
        .rd_data_flat (rd_data_flat),
        .drain_sel    (drain_sel),
        .fill_count   (fill_count)
    );

    function automatic logic [23:0] row(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d, input logic last);
        wr_valid     = 1'b1;
        wr_data_flat = d;
        wr_last      = last;
        step();
        wr_valid     = 1'b0;
        wr_last      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 0; wr_last = 0; wr_data_flat = '0;
        rd_ready = 0; rd_replay = 0;
        step(); step();
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_last", 32'(rd_last), 0);
        chk("rst_rd_data", 32'(rd_data_flat), 0);
        chk("rst_drain_sel", 32'(drain_sel), 0);
        chk("rst_fill_cnt", 32'(fill_count), 0);
        rst_n = 1'b1;
        step();

        // Full batch of four rows, consumer idle
        for (int i = 0; i < 3; i++) push(row(10+i, 20+i, 30+i), 1'b0);
        chk("t1_fill_cnt3", 32'(fill_count), 3);
        chk("t1_no_swap", 32'(drain_sel), 0);
        chk("t1_rd_valid0", 32'(rd_valid), 0);
        push(row(13, 23, 33), 1'b0);
        chk("t1_drain_sel", 32'(drain_sel), 1);
        chk("t1_rd_valid", 32'(rd_valid), 1);
        chk("t1_fill_cnt0", 32'(fill_count), 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_data", 32'(rd_data_flat), 32'(row(10+i, 20+i, 30+i)));
            chk("t1_rd_last", 32'(rd_last), (i == 3) ? 1 : 0);
            step();
        end
        rd_ready = 1'b0;
        chk("t1_released", 32'(rd_valid), 0);
        chk("t1_rd_data0", 32'(rd_data_flat), 0);

        // Short batch closed by wr_last
        push(row(70, 71, 72), 1'b0);
        push(row(73, 74, 75), 1'b1);
        chk("t2_drain_sel", 32'(drain_sel), 0);
        chk("t2_rd_valid", 32'(rd_valid), 1);
        rd_ready = 1'b1;
        chk("t2_row0", 32'(rd_data_flat), 32'(row(70, 71, 72)));
        chk("t2_last0", 32'(rd_last), 0);
        step();
        chk("t2_row1", 32'(rd_data_flat), 32'(row(73, 74, 75)));
        chk("t2_last1", 32'(rd_last), 1);
        step();
        rd_ready = 1'b0;
        chk("t2_released", 32'(rd_valid), 0);

        // Second batch fills behind an undrained first batch
        for (int i = 0; i < 4; i++) push(row(10+i, 20+i, 30+i), 1'b0);
        chk("t3_drain_sel", 32'(drain_sel), 1);
        for (int i = 0; i < 4; i++) push(row(40+i, 50+i, 60+i), 1'b0);
        chk("t3_wr_ready0", 32'(wr_ready), 0);
        chk("t3_fill_cnt4", 32'(fill_count), 4);
        chk("t3_hold_data", 32'(rd_data_flat), 32'(row(10, 20, 30)));
        push(row(99, 99, 99), 1'b1);
        chk("t3_ign_last", 32'(fill_count), 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_rd_data", 32'(rd_data_flat), 32'(row(10+i, 20+i, 30+i)));
            step();
        end
        rd_ready = 1'b0;
        chk("t3_swap_sel", 32'(drain_sel), 0);
        chk("t3_no_bubble", 32'(rd_valid), 1);
        chk("t3_new_row", 32'(rd_data_flat), 32'(row(40, 50, 60)));
        chk("t3_wr_ready1", 32'(wr_ready), 1);

        // Final read and closing write land on the same edge
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_rd_data", 32'(rd_data_flat), 32'(row(40+i, 50+i, 60+i)));
            step();
        end
        rd_ready = 1'b0;
        push(row(1, 2, 3), 1'b0);
        push(row(4, 5, 6), 1'b0);
        push(row(7, 8, 9), 1'b0);
        chk("t4_last_pend", 32'(rd_last), 1);
        rd_ready = 1'b1;
        push(row(100, 101, 102), 1'b1);
        rd_ready = 1'b0;
        chk("t4_drain_sel", 32'(drain_sel), 1);
        chk("t4_rd_valid", 32'(rd_valid), 1);
        chk("t4_wr_ready", 32'(wr_ready), 1);
        chk("t4_row0", 32'(rd_data_flat), 32'(row(1, 2, 3)));
        chk("t4_fill_cnt0", 32'(fill_count), 0);

        // Replay request on the final read
        rd_ready  = 1'b1;
        rd_replay = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rd_replay = 1'b0;
`ifdef DOUBLE_BUFFER_REPLAY_EN
        chk("t5_replay_vld", 32'(rd_valid), 1);
        chk("t5_replay_row", 32'(rd_data_flat), 32'(row(1, 2, 3)));
        for (int i = 0; i < 3; i++) step();
        chk("t5_replay_end", 32'(rd_last), 1);
        step();
`endif
        rd_ready = 1'b0;
        chk("t5_released", 32'(rd_valid), 0);
        chk("t5_drain_sel", 32'(drain_sel), 1);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) push(row(10+i, 20+i, 30+i), 1'b0);
        chk("t6_drain_sel", 32'(drain_sel), 0);
        rd_ready = 1'b1;
        step(); step();
        rd_ready = 1'b0;
        chk("t6_row2", 32'(rd_data_flat), 32'(row(12, 22, 32)));
        push(row(88, 88, 88), 1'b0);
        chk("t6_fill_cnt1", 32'(fill_count), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rd_valid), 0);
        chk("t6_rst_data", 32'(rd_data_flat), 0);
        chk("t6_rst_last", 32'(rd_last), 0);
        chk("t6_rst_fill", 32'(fill_count), 0);
        chk("t6_rst_ready", 32'(wr_ready), 1);
        chk("t6_rst_sel", 32'(drain_sel), 0);
        step();
        rst_n = 1'b1;
        step();
        push(row(5, 6, 7), 1'b1);
        chk("t6_post_sel", 32'(drain_sel), 1);
        chk("t6_post_row", 32'(rd_data_flat), 32'(row(5, 6, 7)));
        chk("t6_post_last", 32'(rd_last), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/double_buffer_stream.md
# double_buffer_stream

Parametrised ping-pong row buffer for the vector datapath: a producer streams MATRIX_SIZE-lane rows into the fill bank while the consumer drains a previously completed batch from the other bank. Banks swap automatically when a fill batch is closed and the drain bank is released, replacing manual load/swap strobes with valid/ready handshakes on both sides. It sits between the operand loader and the compute array, holding up to DEPTH rows per bank.

## Interface
- DATA_WIDTH, 8, bits per lane
- MATRIX_SIZE, 3, lanes per row
- DEPTH, 4, rows per bank (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  producer row valid
- wr_ready  out  1  fill bank can accept a row
- wr_last  in  1  closes batch early with this row (qualified by handshake)
- wr_data_flat  in  DATA_WIDTH*MATRIX_SIZE  row; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  1  drain bank holds a row at rd_ptr
- rd_ready  in  1  consumer accepts row
- rd_last  out  1  current row is final row of batch
- rd_replay  in  1  keep batch for another pass (see Configuration)
- rd_data_flat  out  DATA_WIDTH*MATRIX_SIZE  current drain row, same lane packing
- drain_sel  out  1  index of bank currently draining
- fill_count  out  $clog2(DEPTH+1)  rows written into fill bank

## Operation
- Write accepted on edge where wr_valid && wr_ready; row stored at fill bank[wr_ptr], wr_ptr++.
- Batch closes on the accepting edge when wr_ptr reaches DEPTH-1 or wr_last=1; batch length = rows written (1..DEPTH), stored per bank.
- Per bank state: EMPTY → FILLING (first row) → FULL (close) → DRAINING (swap) → EMPTY (release). Only one bank FILLING/EMPTY-as-fill and one DRAINING at a time.
- Swap: when fill bank is FULL and drain bank is EMPTY, drain_sel toggles, wr_ptr/rd_ptr clear, fill_count clears.
- wr_ready = fill bank not FULL; rd_valid = drain bank DRAINING.
- Read accepted on edge where rd_valid && rd_ready; rd_ptr++. On last row (rd_last) the drain bank is released to EMPTY.
- rd_data_flat = drain bank[rd_ptr] when rd_valid, else all zeros. rd_last = rd_valid && rd_ptr == batch length-1.
- Bank contents are not reset; only state, pointers, lengths.

## Timing
- Reset: drain_sel=0 (bank0 drain, bank1 fill), both EMPTY, wr_ready=1, rd_valid=0, rd_last=0, rd_data_flat=0, fill_count=0.
- Closing write with drain bank EMPTY: swap on that same edge; rd_valid=1 in the next cycle (1-cycle write-to-read latency).
- Closing write with drain bank busy: fill bank FULL, wr_ready=0 until release.
- Final read and closing write on same edge: release and swap on that edge, no bubble; wr_ready=1 and rd_valid=1 next cycle.
- Release with fill bank FULL: swap on release edge; rd_valid stays 1 with new batch next cycle.
- wr_valid=0 or rd_ready=0: all state holds. wr_last while FULL ignored (no handshake).
- rst_n low mid-batch: immediate return to reset values; partial batches discarded.

## Configuration
- DOUBLE_BUFFER_REPLAY_EN defined: rd_replay sampled on final-row read edge; if 1, bank stays DRAINING, rd_ptr wraps to 0, batch streams again; fill bank waits FULL meanwhile.
- Undefined: rd_replay ignored; final read always releases bank. Port still present.

## Structure
- Package dbuf_pkg: bank state enum (EMPTY, FILLING, FULL, DRAINING), row type, pointer/count width function of DEPTH.
- Sub-module dbuf_bank: one DEPTH×row register array with write port (en, addr, data) and combinational read port; instantiated twice.
- Top holds state, pointers, lengths, swap logic.

## Test plan
- Reset release, DATA_WIDTH=8, MATRIX_SIZE=3, DEPTH=4 → wr_ready=1, rd_valid=0, rd_data_flat=0, drain_sel=0.
- Write 4 rows {10,20,30}..{13,23,33}, rd_ready=0 → after 4th write drain_sel=1, rd_valid=1 next cycle, rd_data=[10,20,30]; read 4 rows in order, rd_last on 4th.
- Write 2 rows with wr_last on 2nd → batch length 2, rd_last on row 2, bank released after.
- Fill second batch while first undrained, rd_ready=0 → wr_ready=0 after 4th row; final read edge swaps, rows [40,50,60].. appear next cycle, no bubble.
- Replay build, rd_replay=1 on final read → rows 10..13 stream twice; without macro → released after one pass.
- Assert rst_n low mid-drain with 2 rows read → all outputs at reset values immediately, rd_valid=0.
